mem_responder: RTL and testbench

Multi-cycle data-memory responder that answers the memory stage's load/store requests. It replaces a single-cycle memory model with a small register-file store and a fixed, parameterised service latency. A stall/done handshake tells the pipeline when the access has completed. It serves 16-bit, word-aligned accesses on a 16-bit byte address and flags misaligned requests instead of executing them.

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the memory stage and the multi-cycle data memory.
interface mem_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, stall, done, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, stall, done, err
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle word-addressed data memory with a fixed service latency and
// a stall/done handshake; misaligned requests complete immediately with err.
module mem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LAT        = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus_io
);

  localparam int          Depth = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  LatM1 = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [15:0]             data_out_q, data_out_d;
  logic                    stall_q, stall_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    memWe;
  logic [15:0]             mem_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    stall_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    memWe      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_io.enable) begin
          if (bus_io.addr[0]) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = bus_io.addr[DEPTH_LOG2:1];
            wr_d    = bus_io.wr;
            wdata_d = bus_io.data_in;
            cnt_d   = LatM1;
            stall_d = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          stall_d = 1'b1;
        end else begin
          if (wr_q) begin
            memWe = 1'b1;
          end else begin
            data_out_d = mem_q[idx_q];
          end
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset during BUSY never reaches the write strobe, so no partial store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (memWe) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus_io.data_out = data_out_q;
  assign bus_io.stall    = stall_q;
  assign bus_io.done     = done_q;
  assign bus_io.err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder, with one LAT=2 and one
// LAT=1 instance checked against an array-based memory model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] refMem [2][64];
  logic [15:0] refOut [2];

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  mem_responder #(.DEPTH_LOG2(6), .LAT(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus_io(b0));
  mem_responder #(.DEPTH_LOG2(6), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus_io(b1));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      b0.enable = en; b0.wr = w; b0.addr = a; b0.data_in = d;
    end else begin
      b1.enable = en; b1.wr = w; b1.addr = a; b1.data_in = d;
    end
  endtask

  function automatic logic [3:0] outs(input int sel);
    // {stall, done, err, unused}
    if (sel == 0) return {b0.stall, b0.done, b0.err, 1'b0};
    else          return {b1.stall, b1.done, b1.err, 1'b0};
  endfunction

  function automatic logic [15:0] dataOut(input int sel);
    return (sel == 0) ? b0.data_out : b1.data_out;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      refOut[s] = 16'h0000;
      for (int i = 0; i < 64; i++) refMem[s][i] = 16'h0000;
    end
  endtask

  // One complete request: accept, wait for done within a bound, then idle cycle.
  task automatic applyStimulus(input int sel, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input bit perturb);
    int lat;
    bit mis;
    bit seen;
    int edges;
    int stallCnt;
    int wi;
    logic [3:0] o;
    lat      = (sel == 0) ? 2 : 1;
    mis      = a[0];
    wi       = (int'(a) / 2) % 64;
    seen     = 1'b0;
    edges    = 0;
    stallCnt = 0;
    drive(sel, 1'b1, w, a, d);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      o = outs(sel);
      if (o[2]) begin
        seen = 1'b1;
      end else begin
        edges++;
        if (o[3]) stallCnt++;
        if (perturb) drive(sel, 1'b1, w, a ^ 16'h0002, ~d);
      end
    end
    checkOutput("done_seen", 16'(seen), 16'd1);
    if (seen) begin
      if (!mis) begin
        if (w) refMem[sel][wi] = d;
        else   refOut[sel] = refMem[sel][wi];
      end
      o = outs(sel);
      checkOutput("latency", 16'(edges), mis ? 16'd0 : 16'(lat));
      checkOutput("stall_cycles", 16'(stallCnt), mis ? 16'd0 : 16'(lat));
      checkOutput("err_on_done", 16'(o[1]), 16'(mis));
      checkOutput("stall_on_done", 16'(o[3]), 16'd0);
      checkOutput("data_out", dataOut(sel), refOut[sel]);
    end
    drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk); #1;
    o = outs(sel);
    checkOutput("after_done_flags", {13'd0, o[3:1]}, 16'd0);
    checkOutput("after_done_data", dataOut(sel), refOut[sel]);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rd;
    int          rs;
    logic        rw;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    modelReset();
    #12 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset_flags0", {13'd0, outs(0)[3:1]}, 16'd0);
    checkOutput("reset_data0", dataOut(0), 16'h0000);
    checkOutput("reset_flags1", {13'd0, outs(1)[3:1]}, 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_flags", {13'd0, outs(0)[3:1]}, 16'd0);
      checkOutput("idle_data", dataOut(0), 16'h0000);
    end
    applyStimulus(0, 1'b0, 16'(($urandom % 32768) * 2), 16'h0000, 1'b0);

    applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    checkOutput("load_beef", refOut[0], 16'hBEEF);

    applyStimulus(0, 1'b1, 16'h0011, 16'h1234, 1'b0);
    applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0);

    applyStimulus(0, 1'b1, 16'h0004, 16'hAAAA, 1'b1);
    applyStimulus(0, 1'b0, 16'h0004, 16'h0000, 1'b0);
    applyStimulus(0, 1'b0, 16'h0006, 16'h0000, 1'b0);

    applyStimulus(0, 1'b1, 16'h0080, 16'h00FF, 1'b0);
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b1, 16'(2 * i), 16'(2 * i), 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b0, 16'(2 * i), 16'h0000, 1'b0);

    drive(0, 1'b1, 1'b1, 16'h0002, 16'h7777);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("busy_before_reset", 16'(outs(0)[3]), 16'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("stall_in_reset", 16'(outs(0)[3]), 16'd0);
    modelReset();
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(0, 1'b0, 16'h0002, 16'h0000, 1'b0);
    applyStimulus(1, 1'b1, 16'h0002, 16'h7777, 1'b0);
    applyStimulus(1, 1'b0, 16'h0002, 16'h0000, 1'b0);

    for (int n = 0; n < 80; n++) begin
      rs = int'($urandom % 2);
      rw = 1'($urandom % 2);
      ra = 16'($urandom);
      if (($urandom % 4) != 0) ra[0] = 1'b0;
      rd = 16'($urandom);
      applyStimulus(rs, rw, ra, rd, 1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
